// File: rtl/greyscale_unpack.sv
// -----------------------------------------------------------------------------
// greyscale_unpack
//
// Pulls 32-bit image words from the AHB wrapper's read path, unpacks the byte
// stream as 24-bit B,G,R pixels (pixels straddle word boundaries) and emits
// one 8-bit grey value per pixel on a valid/ready stream:
//     grey = (B + 2*G + R + 2) >> 2
// A single frame_done pulse follows acceptance of the last pixel of a frame.
//
// Ports
//   clk             system clock
//   n_rst           asynchronous, active-low reset
//   start           one-cycle pulse, begins a frame (only honoured in IDLE)
//   pixel_count     pixels in the frame, sampled on start
//   re              one-cycle read request to the wrapper
//   greyscale_data  returned word, [31:24] is the first byte of the file
//   read_complete   one-cycle strobe qualifying greyscale_data
//   pix_out         grey pixel value
//   pix_valid       pix_out valid, held until accepted
//   pix_ready       downstream accepts when pix_valid && pix_ready
//   busy            high while a frame is being fetched or drained
//   frame_done      one-cycle pulse at the end of a frame
// -----------------------------------------------------------------------------
module greyscale_unpack #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [CNT_W-1:0] pixel_count,
    output logic             re,
    input  logic [31:0]      greyscale_data,
    input  logic             read_complete,
    output logic [7:0]       pix_out,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int BUF_BYTES = 8;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] pix_total_reg, pix_total_next;
    logic [CNT_W-1:0] words_total_reg, words_total_next;
    logic [CNT_W-1:0] words_req_reg, words_req_next;
    logic [CNT_W-1:0] words_recv_reg, words_recv_next;
    logic [CNT_W-1:0] pix_formed_reg, pix_formed_next;
    logic [CNT_W-1:0] pix_accepted_reg, pix_accepted_next;
    logic             outstanding_reg, outstanding_next;
    logic             re_reg, re_next;
    logic [7:0]       pix_out_reg, pix_out_next;
    logic             pix_valid_reg, pix_valid_next;
    logic [3:0]       occ_reg, occ_next;

    // Byte buffer contents (slot 0 is the oldest byte) and the incoming word
    // split into file order.
    logic [7:0]       byte_q [0:BUF_BYTES-1];
    logic [7:0]       word_bytes [0:3];

    logic             active;
    logic             push;
    logic             pop;
    logic             accept;
    logic             last_accept;
    logic             req;
    logic [3:0]       occ_base;
    logic [9:0]       grey_sum;
    logic [CNT_W-1:0] words_calc;

    genvar gi;

    // -------------------------------------------------------------------------
    // Control terms
    // -------------------------------------------------------------------------
    assign active      = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign accept      = pix_valid_reg && pix_ready;
    assign last_accept = accept && (pix_accepted_reg == pix_total_reg - CNT_W'(1));

    // A strobe only counts while our single request is outstanding; strays and
    // replies to requests abandoned by a reset fall through here.
    assign push = read_complete && outstanding_reg;

    // A new pixel may be formed when the output register is free or is being
    // emptied this cycle. Stopping at pix_total leaves the trailing pad bytes
    // of the final word in the buffer, where the DONE flush discards them.
    assign pop = active && (occ_reg >= 4'd3) && (!pix_valid_reg || pix_ready) &&
                 (pix_formed_reg != pix_total_reg);

    // Keep at most one request in flight, and only ask for a word when it is
    // guaranteed to fit: occupancy <= 4 leaves room for all 4 bytes.
    assign req = (state_reg == ST_RUN) && !outstanding_reg &&
                 (words_req_reg != words_total_reg) && (occ_reg <= 4'd4);

    // ceil(3*pixel_count/4), with two guard bits so 3*pixel_count cannot wrap.
    assign words_calc = CNT_W'(({2'b00, pixel_count} + {1'b0, pixel_count, 1'b0} +
                                (CNT_W+2)'(3)) >> 2);

    // Max sum is 255 + 510 + 255 + 2 = 1022, so 10 bits never overflow and the
    // shifted result always fits in 8 bits.
    assign grey_sum = {2'b00, byte_q[0]} + {1'b0, byte_q[1], 1'b0} +
                      {2'b00, byte_q[2]} + 10'd2;

    // Where the pushed bytes land: after this cycle's pop has shifted out 3.
    assign occ_base = pop ? (occ_reg - 4'd3) : occ_reg;

    // -------------------------------------------------------------------------
    // Byte buffer: each slot either shifts down by 3 on a pop, takes one of the
    // incoming bytes on a push, or holds.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word_split
            assign word_bytes[gi] = greyscale_data[31-8*gi -: 8];
        end

        for (gi = 0; gi < BUF_BYTES; gi++) begin : g_slot
            logic [7:0] slot_reg;
            logic [7:0] slot_next;
            logic [7:0] shifted;
            logic [3:0] offset;

            if (gi < BUF_BYTES - 3) begin : g_shift
                assign shifted = pop ? byte_q[gi+3] : slot_reg;
            end else begin : g_top
                // Top slots have nothing above them; after a pop their old
                // contents are beyond the occupancy and are don't-care.
                assign shifted = slot_reg;
            end

            // Position of this slot relative to the first free slot; wraps
            // to >= 8 for slots below it, so "< 4" selects exactly 4 slots.
            assign offset = 4'(gi) - occ_base;

            always_comb begin
                slot_next = shifted;
                if (push && (offset < 4'd4)) begin
                    slot_next = word_bytes[offset[1:0]];
                end
            end

            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    slot_reg <= '0;
                end else begin
                    slot_reg <= slot_next;
                end
            end

            assign byte_q[gi] = slot_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next        = state_reg;
        pix_total_next    = pix_total_reg;
        words_total_next  = words_total_reg;
        words_req_next    = words_req_reg;
        words_recv_next   = words_recv_reg;
        pix_formed_next   = pix_formed_reg;
        pix_accepted_next = pix_accepted_reg;
        outstanding_next  = outstanding_reg;
        re_next           = 1'b0;
        pix_out_next      = pix_out_reg;
        pix_valid_next    = pix_valid_reg;
        occ_next          = occ_reg + (push ? 4'd4 : 4'd0) - (pop ? 4'd3 : 4'd0);

        if (push) begin
            words_recv_next  = words_recv_reg + CNT_W'(1);
            outstanding_next = 1'b0;
        end

        if (req) begin
            words_req_next   = words_req_reg + CNT_W'(1);
            outstanding_next = 1'b1;
            re_next          = 1'b1;
        end

        if (pop) begin
            pix_out_next    = 8'(grey_sum >> 2);
            pix_valid_next  = 1'b1;
            pix_formed_next = pix_formed_reg + CNT_W'(1);
        end else if (accept) begin
            pix_valid_next  = 1'b0;
        end

        if (accept) begin
            pix_accepted_next = pix_accepted_reg + CNT_W'(1);
        end

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    pix_total_next    = pixel_count;
                    words_total_next  = words_calc;
                    words_req_next    = '0;
                    words_recv_next   = '0;
                    pix_formed_next   = '0;
                    pix_accepted_next = '0;
                    outstanding_next  = 1'b0;
                    occ_next          = '0;
                    state_next        = (pixel_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_accept) begin
                    state_next = ST_DONE;
                end else if (words_recv_reg == words_total_reg) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_accept) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Entering DONE throws away the pad bytes of the last word.
        if ((state_next == ST_DONE) && (state_reg != ST_DONE)) begin
            occ_next         = '0;
            outstanding_next = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg        <= ST_IDLE;
            pix_total_reg    <= '0;
            words_total_reg  <= '0;
            words_req_reg    <= '0;
            words_recv_reg   <= '0;
            pix_formed_reg   <= '0;
            pix_accepted_reg <= '0;
            outstanding_reg  <= 1'b0;
            re_reg           <= 1'b0;
            pix_out_reg      <= '0;
            pix_valid_reg    <= 1'b0;
            occ_reg          <= '0;
        end else begin
            state_reg        <= state_next;
            pix_total_reg    <= pix_total_next;
            words_total_reg  <= words_total_next;
            words_req_reg    <= words_req_next;
            words_recv_reg   <= words_recv_next;
            pix_formed_reg   <= pix_formed_next;
            pix_accepted_reg <= pix_accepted_next;
            outstanding_reg  <= outstanding_next;
            re_reg           <= re_next;
            pix_out_reg      <= pix_out_next;
            pix_valid_reg    <= pix_valid_next;
            occ_reg          <= occ_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign re         = re_reg;
    assign pix_out    = pix_out_reg;
    assign pix_valid  = pix_valid_reg;
    assign busy       = active;
    assign frame_done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_greyscale_unpack.sv
// -----------------------------------------------------------------------------
// Testbench for greyscale_unpack: a responder answers re pulses with words
// (directed or random) and feeds a byte-stream reference model that pushes
// expected grey pixels into a scoreboard queue; a monitor pops and compares
// on every accepted pixel and checks protocol timing.
// -----------------------------------------------------------------------------
module tb_greyscale_unpack;

    localparam int CNT_W = 20;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] pixel_count = '0;
    logic             re;
    logic [31:0]      greyscale_data;
    logic             read_complete;
    logic [7:0]       pix_out;
    logic             pix_valid;
    logic             pix_ready;
    logic             busy;
    logic             frame_done;

    logic             rc_resp = 1'b0;
    logic             rc_stray = 1'b0;
    logic [31:0]      data_resp = '0;
    logic [31:0]      data_stray = '0;

    assign read_complete  = rc_resp | rc_stray;
    assign greyscale_data = rc_stray ? data_stray : data_resp;

    always #5 clk = ~clk;

    greyscale_unpack #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .start          (start),
        .pixel_count    (pixel_count),
        .re             (re),
        .greyscale_data (greyscale_data),
        .read_complete  (read_complete),
        .pix_out        (pix_out),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    int tests = 0;
    int fails = 0;

    // Reference model and scoreboard
    logic [7:0]  mbytes [$];
    logic [7:0]  expq [$];
    logic [7:0]  got_q [$];
    logic [31:0] word_src [$];
    int frame_pix = 0;
    int formed = 0;
    int accept_cnt = 0;
    int re_cnt = 0;
    int rc_cnt = 0;
    int outstanding = 0;
    int epoch = 0;
    int cyc = 0;
    int start_cyc = -100;
    int last_acc_cyc = -100;
    bit done_seen = 1'b0;
    int ready_mode = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Bytes arrive in file order; every complete B,G,R triple up to the frame's
    // pixel count becomes one expected grey value. Later bytes are padding.
    function automatic void model_word(input logic [31:0] w);
        int b, g, r;
        for (int k = 0; k < 4; k++) mbytes.push_back(w[31-8*k -: 8]);
        while (mbytes.size() >= 3 && formed < frame_pix) begin
            b = int'(mbytes.pop_front());
            g = int'(mbytes.pop_front());
            r = int'(mbytes.pop_front());
            expq.push_back(8'((b + 2*g + r + 2) / 4));
            formed++;
        end
    endfunction

    // Wrapper responder: random 0..3 cycle extra latency per request.
    initial begin : responder
        int ep;
        int d;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (re && n_rst) begin
                ep = epoch;
                d  = $urandom_range(0, 3);
                repeat (d) @(posedge clk);
                @(posedge clk);
                #1;
                if (ep == epoch && n_rst) begin
                    w = (word_src.size() > 0) ? word_src.pop_front() : $urandom;
                    data_resp = w;
                    rc_resp   = 1'b1;
                    model_word(w);
                    @(posedge clk);
                    #1;
                    rc_resp   = 1'b0;
                    data_resp = '0;
                end
            end
        end
    end

    // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
    initial begin : ready_drv
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = ($urandom_range(0, 3) != 0);
                default: pix_ready = 1'b0;
            endcase
        end
    end

    // Monitor: samples on the falling edge, where DUT outputs and bench
    // inputs are both stable.
    initial begin : monitor
        bit hold_prev;
        logic [7:0] hold_val;
        logic [7:0] e;
        hold_prev = 1'b0;
        hold_val  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!n_rst) begin
                outstanding = 0;
                hold_prev   = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("hold_valid", longint'(pix_valid), 1);
                    chk("hold_value", longint'(pix_out), longint'(hold_val));
                end
                hold_prev = pix_valid && !pix_ready;
                hold_val  = pix_out;

                if (re) begin
                    chk("re_while_outstanding", outstanding, 0);
                    outstanding++;
                    re_cnt++;
                end
                if (rc_resp && outstanding > 0) begin
                    outstanding--;
                    rc_cnt++;
                end
                if (start && !busy && !frame_done) start_cyc = cyc;

                if (pix_valid && pix_ready) begin
                    tests++;
                    if (expq.size() == 0) begin
                        fails++;
                        $display("FAIL pixel: got %0h but no pixel expected", pix_out);
                    end else begin
                        e = expq.pop_front();
                        if (pix_out !== e) begin
                            fails++;
                            $display("FAIL pixel %0d: got %0h expected %0h", accept_cnt, pix_out, e);
                        end
                    end
                    got_q.push_back(pix_out);
                    accept_cnt++;
                    last_acc_cyc = cyc;
                end

                if (frame_done) begin
                    done_seen = 1'b1;
                    if (frame_pix == 0) begin
                        chk("zero_done_timing", cyc, start_cyc + 1);
                    end else begin
                        chk("done_after_last_accept", cyc, last_acc_cyc + 1);
                        chk("done_pixel_count", accept_cnt, frame_pix);
                    end
                end
            end
        end
    end

    task automatic new_frame(input int pc);
        mbytes.delete();
        expq.delete();
        got_q.delete();
        frame_pix  = pc;
        formed     = 0;
        accept_cnt = 0;
        re_cnt     = 0;
        rc_cnt     = 0;
        done_seen  = 1'b0;
    endtask

    task automatic pulse_start(input int pc);
        @(posedge clk);
        #1;
        pixel_count = CNT_W'(pc);
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
    endtask

    // Waits for frame_done; optionally fires a mid-frame start at cycle stray_at.
    task automatic wait_done(input string name, input int stray_at);
        int n;
        n = 0;
        while (!done_seen && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == stray_at && !done_seen) begin
                pixel_count = CNT_W'(9);
                start       = 1'b1;
                @(posedge clk);
                #1;
                start       = 1'b0;
                n++;
            end
        end
        tests++;
        if (!done_seen) begin
            fails++;
            $display("FAIL %s_timeout: frame_done not seen after %0d cycles", name, n);
        end
        @(negedge clk);
        chk({name, "_busy_after"}, longint'(busy), 0);
        chk({name, "_scoreboard_left"}, expq.size(), 0);
        chk({name, "_re_count"}, re_cnt, (3 * frame_pix + 3) / 4);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_re"}, longint'(re), 0);
        chk({name, "_pix_out"}, longint'(pix_out), 0);
        chk({name, "_pix_valid"}, longint'(pix_valid), 0);
        chk({name, "_busy"}, longint'(busy), 0);
        chk({name, "_frame_done"}, longint'(frame_done), 0);
    endtask

    task automatic chk_got(input string name, input logic [7:0] exp [4]);
        chk({name, "_count"}, got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            chk($sformatf("%s_pix%0d", name, i), longint'(got_q[i]), longint'(exp[i]));
        end
    endtask

    initial begin : main
        logic [7:0] basic_exp [4];
        logic [7:0] ff_exp [4];
        logic [7:0] zero_exp [4];
        int n;
        int pc;
        basic_exp = '{8'h20, 8'h50, 8'h80, 8'hB0};
        ff_exp    = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        zero_exp  = '{8'h00, 8'h00, 8'h00, 8'h00};

        // Reset state
        n_rst = 1'b0;
        #2;
        chk_outputs_zero("reset");
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Stray read_complete in IDLE must not enter the buffer
        data_stray = 32'hDEADBEEF;
        rc_stray   = 1'b1;
        @(posedge clk);
        #1;
        rc_stray   = 1'b0;
        data_stray = '0;
        repeat (2) @(negedge clk);
        chk("stray_pix_valid", longint'(pix_valid), 0);
        chk("stray_busy", longint'(busy), 0);

        // Basic unpack, with an ignored start pulse mid-frame
        ready_mode = 0;
        new_frame(4);
        word_src = {32'h10203040, 32'h50607080, 32'h90A0B0C0};
        pulse_start(4);
        wait_done("basic", 5);
        chk_got("basic", basic_exp);

        // Saturation edges
        new_frame(4);
        word_src = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        pulse_start(4);
        wait_done("all_ff", 0);
        chk_got("all_ff", ff_exp);

        new_frame(4);
        word_src = {32'h0, 32'h0, 32'h0};
        pulse_start(4);
        wait_done("all_zero", 0);
        chk_got("all_zero", zero_exp);

        // Partial final word: last byte 0xFF is padding
        new_frame(5);
        word_src = {32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'h0A141EFF};
        pulse_start(5);
        wait_done("partial", 0);
        chk("partial_count", got_q.size(), 5);
        if (got_q.size() == 5) chk("partial_pix4", longint'(got_q[4]), 'h14);

        // Backpressure: 20 stalled cycles, buffer fills to >4 and requests stop
        ready_mode = 2;
        new_frame(8);
        pulse_start(8);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("bp_re_count", re_cnt, 2);
        chk("bp_pix_valid", longint'(pix_valid), 1);
        ready_mode = 1;
        wait_done("backpressure", 0);

        // Zero-length frame
        ready_mode = 0;
        new_frame(0);
        pulse_start(0);
        wait_done("zero", 0);

        // Reset in the middle of a frame, after the second word
        ready_mode = 1;
        new_frame(4);
        pulse_start(4);
        n = 0;
        while (rc_cnt < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("midreset_words_before", rc_cnt >= 2 ? 1 : 0, 1);
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        epoch++;
        #1;
        chk_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        ready_mode = 0;
        new_frame(4);
        word_src = {32'h10203040, 32'h50607080, 32'h90A0B0C0};
        pulse_start(4);
        wait_done("after_reset", 0);
        chk_got("after_reset", basic_exp);

        // Random frames with random backpressure
        ready_mode = 1;
        for (int f = 0; f < 6; f++) begin
            pc = $urandom_range(1, 30);
            new_frame(pc);
            pulse_start(pc);
            wait_done($sformatf("rand%0d", f), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
